// File: rtl/fifo_burst_drain_ctrl.sv
// fifo_burst_drain_ctrl: drains the async FIFO read port into fixed-length DDR write bursts with linear frame addressing
module fifo_burst_drain_ctrl #(
  parameter int DATA_W         = 64,
  parameter int LVL_W          = 11,
  parameter int ADDR_W         = 28,
  parameter int BURST_LEN      = 16,
  parameter int BYTES_PER_BEAT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_empty,
  input  logic [LVL_W-1:0]  fifo_rd_water_level,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_len,
  input  logic              wr_ack,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              wr_last,
  output logic              busy,
  output logic              frame_done
);
  typedef enum logic [1:0] {IDLE, REQ, DATA, FDONE} state_t;
  state_t            state;
  logic [8:0]        len, beats_read, beats_sent, plen;
  logic [ADDR_W-1:0] offset, frame_base, base_now;
  logic              flush_pend, started, inflight, pop;
  logic [DATA_W-1:0] q0, q1;
  logic [1:0]        count, cnt_pop;
  // a partial flush burst never exceeds a full burst even when enable is low
  assign plen       = fifo_rd_water_level < LVL_W'(BURST_LEN) ? 9'(fifo_rd_water_level) : 9'(BURST_LEN);
  assign base_now   = started ? frame_base : base_addr;
  assign busy       = state != IDLE;
  assign wr_valid   = count != 2'd0;
  assign wr_data    = q0;
  assign pop        = wr_valid && wr_ready;
  assign cnt_pop    = count - 2'(pop);
  assign wr_last    = wr_valid && (beats_sent + 9'd1 == len);
  assign fifo_rd_en = state == DATA && beats_read < len && !fifo_rd_empty &&
                      ({1'b0, count} + {2'b0, inflight}) < 3'd2;
  // two-entry skid buffer absorbing the one-cycle FIFO read latency
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q0       <= '0;
      q1       <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      q0       <= inflight && cnt_pop == 2'd0 ? fifo_rd_data : pop ? q1 : q0;
      q1       <= inflight && cnt_pop == 2'd1 ? fifo_rd_data : q1;
      count    <= cnt_pop + 2'(inflight);
      inflight <= fifo_rd_en;
    end
  // burst scheduler: picks full or flush bursts, issues requests, closes frames
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      len        <= '0;
      beats_read <= '0;
      beats_sent <= '0;
      offset     <= '0;
      frame_base <= '0;
      flush_pend <= 1'b0;
      started    <= 1'b0;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      wr_len     <= '0;
      frame_done <= 1'b0;
    end else begin
      started    <= 1'b1;
      if (!started) frame_base <= base_addr;
      flush_pend <= flush | (flush_pend & (state != FDONE));
      frame_done <= 1'b0;
      case (state)
        IDLE:
          if (enable && fifo_rd_water_level >= LVL_W'(BURST_LEN)) begin
            state   <= REQ;
            len     <= 9'(BURST_LEN);
            wr_req  <= 1'b1;
            wr_addr <= base_now + offset;
            wr_len  <= 8'(BURST_LEN - 1);
          end else if (flush_pend && fifo_rd_water_level != '0) begin
            state   <= REQ;
            len     <= plen;
            wr_req  <= 1'b1;
            wr_addr <= base_now + offset;
            wr_len  <= 8'(plen - 9'd1);
          end else if (flush_pend) begin
            state      <= FDONE;
            frame_done <= 1'b1;
          end
        REQ:
          if (wr_ack) begin
            state      <= DATA;
            wr_req     <= 1'b0;
            beats_read <= '0;
            beats_sent <= '0;
          end
        DATA: begin
          beats_read <= beats_read + 9'(fifo_rd_en);
          beats_sent <= beats_sent + 9'(pop);
          if (pop && wr_last) begin
            offset <= offset + ADDR_W'(len) * ADDR_W'(BYTES_PER_BEAT);
            state  <= IDLE;
          end
        end
        FDONE: begin
          offset     <= '0;
          frame_base <= base_addr;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fifo_burst_drain_ctrl.sv
// tb_fifo_burst_drain_ctrl: directed scenarios for the burst drain controller
module tb_fifo_burst_drain_ctrl;
  localparam logic [27:0] B1 = 28'h0100000;
  localparam logic [27:0] B2 = 28'h0200040;
  localparam logic [27:0] B3 = 28'h0ABC000;
  localparam logic [27:0] B4 = 28'h0333000;
  logic        clk = 1'b0;
  logic        rst_n, enable, flush, wr_ack, wr_ready;
  logic [27:0] base_addr;
  logic        fifo_rd_en, fifo_rd_empty;
  logic [63:0] fifo_rd_data = '0;
  logic [10:0] fifo_rd_water_level;
  logic        wr_req, wr_valid, wr_last, busy, frame_done;
  logic [27:0] wr_addr;
  logic [7:0]  wr_len;
  logic [63:0] wr_data;
  logic [63:0] mem [256];
  int          wp = 0, rp = 0, phase = 0;
  bit          rdy_mode = 1'b0, ack_en = 1'b1;
  logic [63:0] beats[$];
  logic        lasts[$];
  logic [27:0] addrs[$];
  logic [7:0]  lens[$];
  int          fd_count = 0, rd_total = 0, xf_total = 0, viol = 0;
  int          total = 0, bad = 0;

  fifo_burst_drain_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .base_addr(base_addr),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_len(wr_len), .wr_ack(wr_ack), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_last(wr_last), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign fifo_rd_water_level = 11'(wp - rp);
  assign fifo_rd_empty       = (wp == rp);
  assign wr_ack              = ack_en;
  assign wr_ready            = rdy_mode ? (phase == 0) : 1'b1;

  // FIFO read port model: data appears one cycle after the read enable
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rp[7:0]];
      rp <= rp + 1;
    end
    phase <= (phase == 2) ? 0 : phase + 1;
  end

  // monitor: logs what happens at the coming rising edge
  always @(negedge clk) begin
    if (fifo_rd_en && rd_total - xf_total >= 2) viol++;
    if (fifo_rd_en) rd_total++;
    if (wr_valid && wr_ready) begin
      beats.push_back(wr_data);
      lasts.push_back(wr_last);
      xf_total++;
    end
    if (wr_req && wr_ack) begin
      addrs.push_back(wr_addr);
      lens.push_back(wr_len);
    end
    if (frame_done) fd_count++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      mem[wp[7:0]] = 64'(start + i);
      wp++;
    end
  endtask

  task automatic clear_logs();
    beats.delete(); lasts.delete(); addrs.delete(); lens.delete();
    fd_count = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; base_addr = B1;
    #2;
    total++;
    if ({fifo_rd_en, wr_req, wr_valid, wr_last, busy, frame_done, wr_addr, wr_len, wr_data} !== '0) begin
      bad++; $display("FAIL reset_outputs got req=%b valid=%b busy=%b addr=%h data=%h want all 0", wr_req, wr_valid, busy, wr_addr, wr_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_burst();
    clear_logs(); enable = 1'b1; push(16, 0); cyc(60);
    push(16, 16); cyc(60);
    total++;
    if (addrs.size() != 2 || beats.size() != 32) begin
      bad++; $display("FAIL single_counts got reqs=%0d beats=%0d want 2 32", addrs.size(), beats.size());
    end else begin
      total++;
      if (addrs[0] !== B1 || lens[0] !== 8'd15) begin
        bad++; $display("FAIL single_req0 got addr=%h len=%0d want %h 15", addrs[0], lens[0], B1);
      end
      total++;
      if (addrs[1] !== B1 + 28'd128 || lens[1] !== 8'd15) begin
        bad++; $display("FAIL single_req1 got addr=%h len=%0d want %h 15", addrs[1], lens[1], B1 + 28'd128);
      end
      for (int i = 0; i < 32; i++) begin
        total++;
        if (beats[i] !== 64'(i) || lasts[i] !== (i % 16 == 15)) begin
          bad++; $display("FAIL single_beat%0d got data=%0d last=%b want %0d %b", i, beats[i], lasts[i], i, i % 16 == 15);
        end
      end
    end
  endtask

  task automatic test_ready_toggle();
    clear_logs(); viol = 0; rdy_mode = 1'b1; push(16, 200); cyc(120);
    rdy_mode = 1'b0;
    total++;
    if (beats.size() != 16 || addrs.size() != 1) begin
      bad++; $display("FAIL toggle_counts got beats=%0d reqs=%0d want 16 1", beats.size(), addrs.size());
    end else begin
      total++;
      if (addrs[0] !== B1 + 28'd256) begin
        bad++; $display("FAIL toggle_addr got %h want %h", addrs[0], B1 + 28'd256);
      end
      for (int i = 0; i < 16; i++) begin
        total++;
        if (beats[i] !== 64'(200 + i) || lasts[i] !== (i == 15)) begin
          bad++; $display("FAIL toggle_beat%0d got data=%0d last=%b want %0d %b", i, beats[i], lasts[i], 200 + i, i == 15);
        end
      end
    end
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL toggle_overread got %0d reads with 2 outstanding want 0", viol);
    end
  endtask

  task automatic test_partial_flush();
    clear_logs(); push(5, 300); cyc(5);
    base_addr = B2; flush = 1'b1; cyc(1); flush = 1'b0; cyc(60);
    total++;
    if (addrs.size() != 1 || beats.size() != 5) begin
      bad++; $display("FAIL partial_counts got reqs=%0d beats=%0d want 1 5", addrs.size(), beats.size());
    end else begin
      total++;
      if (addrs[0] !== B1 + 28'd384 || lens[0] !== 8'd4) begin
        bad++; $display("FAIL partial_req got addr=%h len=%0d want %h 4", addrs[0], lens[0], B1 + 28'd384);
      end
      for (int i = 0; i < 5; i++) begin
        total++;
        if (beats[i] !== 64'(300 + i) || lasts[i] !== (i == 4)) begin
          bad++; $display("FAIL partial_beat%0d got data=%0d last=%b want %0d %b", i, beats[i], lasts[i], 300 + i, i == 4);
        end
      end
    end
    total++;
    if (fd_count != 1) begin
      bad++; $display("FAIL partial_frame_done got %0d pulses want 1", fd_count);
    end
    clear_logs(); push(16, 350); cyc(60);
    total++;
    if (addrs.size() != 1 || addrs[0] !== B2 || beats.size() != 16) begin
      bad++; $display("FAIL new_frame_addr got reqs=%0d beats=%0d want 1 16 at %h", addrs.size(), beats.size(), B2);
    end
  endtask

  task automatic test_flush_multi();
    clear_logs(); base_addr = B3; flush = 1'b1; cyc(1); flush = 1'b0; cyc(10);
    total++;
    if (fd_count != 1 || addrs.size() != 0) begin
      bad++; $display("FAIL empty_flush got done=%0d reqs=%0d want 1 0", fd_count, addrs.size());
    end
    clear_logs(); push(40, 400); flush = 1'b1; cyc(1); flush = 1'b0; cyc(200);
    total++;
    if (addrs.size() != 3 || beats.size() != 40) begin
      bad++; $display("FAIL multi_counts got reqs=%0d beats=%0d want 3 40", addrs.size(), beats.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (addrs[i] !== B3 + 28'(128 * i) || lens[i] !== (i == 2 ? 8'd7 : 8'd15)) begin
          bad++; $display("FAIL multi_req%0d got addr=%h len=%0d want %h %0d", i, addrs[i], lens[i], B3 + 28'(128 * i), i == 2 ? 7 : 15);
        end
      end
      for (int i = 0; i < 40; i++) begin
        total++;
        if (beats[i] !== 64'(400 + i) || lasts[i] !== (i == 15 || i == 31 || i == 39)) begin
          bad++; $display("FAIL multi_beat%0d got data=%0d last=%b want %0d", i, beats[i], lasts[i], 400 + i);
        end
      end
    end
    total++;
    if (fd_count != 1) begin
      bad++; $display("FAIL multi_frame_done got %0d pulses want 1", fd_count);
    end
  endtask

  task automatic test_ack_hold();
    clear_logs(); ack_en = 1'b0; push(16, 500); cyc(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (wr_req !== 1'b1 || wr_addr !== B3 || wr_len !== 8'd15 || fifo_rd_en !== 1'b0) begin
        bad++; $display("FAIL ack_hold%0d got req=%b addr=%h len=%0d rd=%b want 1 %h 15 0", i, wr_req, wr_addr, wr_len, fifo_rd_en, B3);
      end
    end
    cyc(1); ack_en = 1'b1; cyc(60);
    total++;
    if (addrs.size() != 1 || beats.size() != 16) begin
      bad++; $display("FAIL ack_counts got reqs=%0d beats=%0d want 1 16", addrs.size(), beats.size());
    end else begin
      total++;
      if (beats[0] !== 64'd500 || beats[15] !== 64'd515 || lasts[15] !== 1'b1) begin
        bad++; $display("FAIL ack_data got first=%0d last=%0d want 500 515", beats[0], beats[15]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_logs(); enable = 1'b1; push(16, 600);
    for (int i = 0; i < 100 && beats.size() < 7; i++) @(negedge clk);
    total++;
    if (beats.size() != 7 || busy !== 1'b1) begin
      bad++; $display("FAIL mid_reach got beats=%0d busy=%b want 7 1", beats.size(), busy);
    end
    #2 enable = 1'b0; base_addr = B4; rst_n = 1'b0;
    #1;
    total++;
    if ({fifo_rd_en, wr_req, wr_valid, wr_last, busy, frame_done, wr_addr, wr_len, wr_data} !== '0) begin
      bad++; $display("FAIL mid_reset_outputs got rd=%b valid=%b last=%b busy=%b data=%h want all 0", fifo_rd_en, wr_valid, wr_last, busy, wr_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(3);
    total++;
    if (busy !== 1'b0 || wr_req !== 1'b0) begin
      bad++; $display("FAIL mid_idle got busy=%b req=%b want 0 0", busy, wr_req);
    end
    clear_logs(); enable = 1'b1; push(16, 700); cyc(80);
    total++;
    if (addrs.size() != 1 || addrs[0] !== B4 || lens[0] !== 8'd15) begin
      bad++; $display("FAIL mid_restart got reqs=%0d addr=%h want 1 %h", addrs.size(), addrs.size() ? addrs[0] : 28'd0, B4);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_ready_toggle();
    test_partial_flush();
    test_flush_multi();
    test_ack_hold();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
